uart_tx_framed: RTL and testbench
=================================

Name: uart_tx_framed

Overview:
- Parametrised successor UART transmitter with a fully synchronous, single-clock design; no tick-clocked logic.
- Internal baud divider; configurable data bits, parity mode (none/even/odd) and stop bits.
- Valid/ready input handshake backed by a one-word holding register, so frames go out back-to-back with no idle gap.
- Sits between a byte-producing core (FIFO or CPU bus bridge) and the serial TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- Derived: DIVISOR = CLK_FREQ / BAUD_RATE (integer division); must be >= 2.
- Any illegal parameter value is an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  producer has a word on s_data.
- s_data  input  DATA_BITS  word to transmit; sent LSB first.
- s_ready  output  1  holding register empty; word is accepted on an edge where s_valid && s_ready.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  FSM not in IDLE, or holding register full.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs):
  - On the next edge: tx=1, s_ready=1, busy=0, tx_done=0, FSM=IDLE, holding register empty, divider=0, bit counter=0.
  - Asserting reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- Handshake:
  - On an accept edge, s_data is copied into the holding register.
  - s_ready = !hold_full.
  - s_data is ignored on any edge where s_ready=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every bit period lasts exactly DIVISOR clk cycles.
- Divider: counts 0..DIVISOR-1 and is restarted to 0 on entry to START. It is not free-running, so latency is deterministic.
- IDLE -> START:
  - Taken on the first edge where hold_full=1. On that edge: shifter <= holding register, hold_full <= 0, tx <= 0, parity bit computed.
  - Latency: accept at edge E0 gives tx low from E1 (one cycle).
  - If accept and the load would coincide, the word is loaded at the following edge.
- START -> DATA: after DIVISOR cycles; tx <= shifter[0].
- DATA:
  - On each bit boundary the shifter shifts right and tx <= next LSB.
  - After DATA_BITS periods, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - tx = ^data when PARITY_MODE = 1, ~^data when PARITY_MODE = 2.
  - One period, then STOP.
- STOP:
  - tx = 1 for STOP_BITS periods.
  - On the edge ending the last period, tx_done = 1 for exactly one cycle.
  - Then go to START if hold_full (tx <= 0 on that same edge, zero idle cycles), else IDLE.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × DIVISOR cycles.
- A second word may be accepted while a frame is in flight (from the edge after the load). A third is back-pressured until the next load.
- Counter width = $clog2 of the maximum count, with no wrap before terminal count. Bit counter sized for DATA_BITS = 9 and STOP_BITS = 2.

Test Plan:
- Basic frame: DATA_BITS=8, PARITY_MODE=0, STOP_BITS=1, CLK_FREQ=1000000, BAUD_RATE=100000 (DIVISOR=10); send 0xA5.
  - tx low cycles 1–10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  - tx_done pulses at cycle 100; busy deasserts at cycle 100.
- Parity: same clocking; 8E1 with 0x07 -> parity bit 1, frame 110 cycles. 8O1 with 0x07 -> parity bit 0.
- Back-to-back: s_valid held with 0x55 then 0xAA.
  - Second word accepted during the first frame; s_ready=0 while holding is full.
  - Start bit of 0xAA begins on the cycle immediately after the 0x55 stop bit.
  - tx_done pulses exactly 100 cycles apart.
- 7-data-bit, 2-stop format: DATA_BITS=7, STOP_BITS=2, send 0x41 -> bits 1,0,0,0,0,0,1; stop high for 20 cycles; frame 100 cycles.
- Reset mid-frame: reset asserted at cycle 35 of a 0xA5 frame -> next edge tx=1, busy=0, s_ready=1, no tx_done; a following 0x3C frame is bit-exact.
- Backpressure: with holding full, toggle s_data each cycle -> only the value present on the accept edge is transmitted.

Source files
------------

// File: rtl/uart_tx_framed_if.sv
// Word handshake between a byte producer and the UART transmitter.
// The producer (master) offers s_data with s_valid; the transmitter (slave) answers with s_ready.
interface uart_tx_framed_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;
    logic                 s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: internal baud divider, optional parity, 1/2 stop bits,
// and a one-word holding register so that consecutive frames leave with no idle gap.
module uart_tx_framed #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned BAUD_RATE   = 9600
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_framed_if.slave    s_if,
    output logic               tx,
    output logic               busy,
    output logic               tx_done
);
    localparam int unsigned DIVISOR  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned DIV_W    = (DIVISOR >= 2) ? $clog2(DIVISOR) : 1;
    localparam int unsigned BIT_W    = $clog2(10);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
    end
    if (BAUD_RATE == 0 || DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx_framed: CLK_FREQ / BAUD_RATE must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q,     state_d;
    logic                 tx_q,        tx_d;
    logic                 tx_done_q,   tx_done_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 parity_q,    parity_d;
    logic [DIV_W-1:0]     div_q,       div_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;

    logic div_end;

    assign div_end    = (div_q == DIV_W'(DIVISOR - 1));
    assign s_if.s_ready = ~hold_full_q;
    assign tx         = tx_q;
    assign tx_done    = tx_done_q;
    assign busy       = (state_q != IDLE) || hold_full_q;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        tx_done_d   = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        div_d       = div_end ? '0 : div_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;

        // Loading and accepting are exclusive: a load needs hold_full, an accept needs it clear.
        if (s_if.s_valid && !hold_full_q) begin
            hold_d      = s_if.s_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (hold_full_q) begin
                    state_d     = START;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    parity_d    = (PARITY_MODE == 1) ? ^hold_q : ~^hold_q;
                end
            end
            START: begin
                if (div_end) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (div_end) begin
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY_MODE != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (div_end) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (div_end) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        tx_done_d = 1'b1;
                        bit_cnt_d = '0;
                        // A waiting word starts on this same edge, giving zero idle cycles.
                        if (hold_full_q) begin
                            state_d     = START;
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            tx_d        = 1'b0;
                            div_d       = '0;
                            parity_d    = (PARITY_MODE == 1) ? ^hold_q : ~^hold_q;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: 8N1, 8E1, 8O1 and 7N2 instances at DIVISOR = 10,
// frames compared cycle by cycle against hand-written bit patterns (first character sent first).
module tb_uart_tx_framed;
    localparam int DIV = 10;

    logic       clk;
    logic       reset;
    logic       valid_a [4];
    logic [8:0] data_a  [4];
    logic       tx_a    [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic       rdy_a   [4];

    int checks = 0;
    int passes = 0;

    uart_tx_framed_if #(.DATA_BITS(8)) if0 ();
    uart_tx_framed_if #(.DATA_BITS(8)) if1 ();
    uart_tx_framed_if #(.DATA_BITS(8)) if2 ();
    uart_tx_framed_if #(.DATA_BITS(7)) if3 ();

    assign if0.s_valid = valid_a[0];
    assign if1.s_valid = valid_a[1];
    assign if2.s_valid = valid_a[2];
    assign if3.s_valid = valid_a[3];
    assign if0.s_data  = data_a[0][7:0];
    assign if1.s_data  = data_a[1][7:0];
    assign if2.s_data  = data_a[2][7:0];
    assign if3.s_data  = data_a[3][6:0];
    assign rdy_a[0]    = if0.s_ready;
    assign rdy_a[1]    = if1.s_ready;
    assign rdy_a[2]    = if2.s_ready;
    assign rdy_a[3]    = if3.s_ready;

    uart_tx_framed #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0),
                     .CLK_FREQ(1000000), .BAUD_RATE(100000)) dut0 (
        .clk(clk), .reset(reset), .s_if(if0),
        .tx(tx_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]));
    uart_tx_framed #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1),
                     .CLK_FREQ(1000000), .BAUD_RATE(100000)) dut1 (
        .clk(clk), .reset(reset), .s_if(if1),
        .tx(tx_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]));
    uart_tx_framed #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(2),
                     .CLK_FREQ(1000000), .BAUD_RATE(100000)) dut2 (
        .clk(clk), .reset(reset), .s_if(if2),
        .tx(tx_a[2]), .busy(busy_a[2]), .tx_done(done_a[2]));
    uart_tx_framed #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_MODE(0),
                     .CLK_FREQ(1000000), .BAUD_RATE(100000)) dut3 (
        .clk(clk), .reset(reset), .s_if(if3),
        .tx(tx_a[3]), .busy(busy_a[3]), .tx_done(done_a[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle index c is the c-th cycle after the start-bit edge; each bit window is one check.
    task automatic check_frame(input int sel, input string pat, input int first_c, input bit now,
                               input int last_c, input bit toggle);
        int n;
        int stop_c;
        int ok;
        int samp;
        int done_hi;
        int rdy_hi;
        logic exp_b;
        n       = pat.len() * DIV;
        stop_c  = (last_c < 0) ? n : last_c;
        ok      = 0;
        samp    = 0;
        done_hi = 0;
        rdy_hi  = 0;
        for (int c = first_c; c < stop_c; c++) begin
            if (!(now && c == first_c)) @(negedge clk);
            exp_b = (pat[c / DIV] == 8'h31);
            if (tx_a[sel] === exp_b) ok++;
            samp++;
            if (c >= 1 && done_a[sel] !== 1'b0) done_hi++;
            if (toggle) begin
                if (rdy_a[sel] !== 1'b0) rdy_hi++;
                data_a[sel] = 9'($urandom);
            end
            if ((c % DIV) == DIV - 1 || c == stop_c - 1) begin
                chk($sformatf("dut%0d frame bit %0d cycles", sel, c / DIV), ok, samp);
                ok   = 0;
                samp = 0;
            end
        end
        chk($sformatf("dut%0d no early tx_done", sel), done_hi, 0);
        if (toggle) begin
            chk("backpressure s_ready low", rdy_hi, 0);
            valid_a[sel] = 1'b0;
        end
    endtask

    task automatic end_check(input int sel, input bit more);
        @(negedge clk);
        chk($sformatf("dut%0d tx_done pulse", sel), done_a[sel], 1);
        chk($sformatf("dut%0d tx after frame", sel), tx_a[sel], more ? 0 : 1);
        chk($sformatf("dut%0d busy after frame", sel), busy_a[sel], more ? 1 : 0);
        if (!more) begin
            @(negedge clk);
            chk($sformatf("dut%0d tx_done one cycle", sel), done_a[sel], 0);
            chk($sformatf("dut%0d tx idle", sel), tx_a[sel], 1);
        end
    endtask

    task automatic send(input int sel, input logic [8:0] d);
        @(negedge clk);
        valid_a[sel] = 1'b1;
        data_a[sel]  = d;
        @(posedge clk);
        @(negedge clk);
        valid_a[sel] = 1'b0;
        chk($sformatf("dut%0d s_ready after accept", sel), rdy_a[sel], 0);
        chk($sformatf("dut%0d tx before start", sel), tx_a[sel], 1);
        chk($sformatf("dut%0d busy after accept", sel), busy_a[sel], 1);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dut%0d reset tx", i), tx_a[i], 1);
            chk($sformatf("dut%0d reset s_ready", i), rdy_a[i], 1);
            chk($sformatf("dut%0d reset busy", i), busy_a[i], 0);
            chk($sformatf("dut%0d reset tx_done", i), done_a[i], 0);
        end
        reset = 1'b0;

        // 8N1 0xA5
        send(0, 9'h0A5);
        check_frame(0, "0101001011", 0, 1'b0, -1, 1'b0);
        end_check(0, 1'b0);

        // 8E1 0x07 -> parity 1, 8O1 0x07 -> parity 0
        send(1, 9'h007);
        check_frame(1, "01110000011", 0, 1'b0, -1, 1'b0);
        end_check(1, 1'b0);
        send(2, 9'h007);
        check_frame(2, "01110000001", 0, 1'b0, -1, 1'b0);
        end_check(2, 1'b0);

        // 7N2 0x41
        send(3, 9'h041);
        check_frame(3, "0100000111", 0, 1'b0, -1, 1'b0);
        end_check(3, 1'b0);

        // Back-to-back 0x55 then 0xAA, with s_data scrambled while the holding register is full
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h055;
        @(posedge clk);
        @(negedge clk);
        chk("b2b s_ready after first accept", rdy_a[0], 0);
        chk("b2b tx before start", tx_a[0], 1);
        data_a[0] = 9'h0AA;
        @(negedge clk);
        chk("b2b start bit latency", tx_a[0], 0);
        chk("b2b s_ready after load", rdy_a[0], 1);
        @(negedge clk);
        chk("b2b s_ready after second accept", rdy_a[0], 0);
        check_frame(0, "0101010101", 1, 1'b1, -1, 1'b1);
        end_check(0, 1'b1);
        check_frame(0, "0010101011", 0, 1'b1, -1, 1'b0);
        end_check(0, 1'b0);

        // Reset at cycle 35 of a 0xA5 frame, then a clean 0x3C frame
        send(0, 9'h0A5);
        check_frame(0, "0101001011", 0, 1'b0, 35, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid reset tx", tx_a[0], 1);
        chk("mid reset busy", busy_a[0], 0);
        chk("mid reset s_ready", rdy_a[0], 1);
        chk("mid reset tx_done", done_a[0], 0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_a[0] !== 1'b1 || done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) bad++;
        end
        chk("post reset line quiet", bad, 0);
        send(0, 9'h03C);
        check_frame(0, "0001111001", 0, 1'b0, -1, 1'b0);
        end_check(0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
